usrt_tx_framer: RTL and testbench

- Transmit-side USRT stage sitting directly downstream of the APB write register and upstream of the serial TX line.
- Buffers bytes written from the APB side in a small FIFO.
- Frames each byte as start / 8 data bits (LSB first) / optional parity / stop.
- Shifts frames out one bit per baud tick on the pClk domain.

---
 rtl/usrt_tx_framer.sv | 146 ++++++++++++++
 tb/tb_usrt_tx_framer.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/usrt_tx_framer.sv
// Transmit framer for the USRT: a small byte FIFO feeding a start/data/parity/stop
// shifter that emits one bit per baud_tick, LSB first, with no gap between queued frames.
module usrt_tx_framer #(
    parameter int FIFO_DEPTH = 4,
    parameter bit PARITY_EN  = 1'b1,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic                            pClk,
    input  logic                            pReset,
    input  logic                            wr_valid,
    input  logic [7:0]                      wr_data,
    output logic                            wr_ready,
    input  logic                            baud_tick,
    output logic                            tx,
    output logic                            busy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_level
);
    localparam int LW    = $clog2(FIFO_DEPTH + 1);
    localparam int PW    = $clog2(FIFO_DEPTH);
    localparam int NBITS = PARITY_EN ? 11 : 10;
    localparam logic [3:0]    LAST_BIT   = 4'(NBITS - 1);
    localparam logic [LW-1:0] FULL_LEVEL = LW'(FIFO_DEPTH);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    logic [7:0]    fifoMem_r [FIFO_DEPTH];
    logic [PW-1:0] rdPtr_r;
    logic [PW-1:0] wrPtr_r;
    logic [LW-1:0] level_r;
    logic [LW-1:0] levelNext_s;
    logic          wrReady_r;
    state_t        state_r;
    logic [10:0]   shift_r;
    logic [3:0]    bitCnt_r;
    logic          tx_r;
    logic          busy_r;
    logic          pushReq_s;
    logic          popReq_s;
    logic          frameEnd_s;
    logic [10:0]   popFrame_s;

    function automatic logic parityOf(input logic [7:0] d);
        return (^d) ^ PARITY_ODD;
    endfunction

    // Without parity, bit 9 is the stop bit and bit 10 is never shifted out.
    function automatic logic [10:0] frameOf(input logic [7:0] d);
        logic pBit;
        pBit = PARITY_EN ? parityOf(d) : 1'b1;
        return {1'b1, pBit, d, 1'b0};
    endfunction

    // Push/pop qualification and the next FIFO occupancy.
    always_comb begin
        pushReq_s   = wr_valid && wrReady_r;
        frameEnd_s  = (state_r == SHIFT) && (bitCnt_r == LAST_BIT);
        popReq_s    = baud_tick && (level_r != '0) && ((state_r == IDLE) || frameEnd_s);
        popFrame_s  = frameOf(fifoMem_r[rdPtr_r]);
        levelNext_s = level_r;
        case ({pushReq_s, popReq_s})
            2'b10:   levelNext_s = level_r + LW'(1);
            2'b01:   levelNext_s = level_r - LW'(1);
            default: levelNext_s = level_r;
        endcase
    end

    // FIFO storage, pointers and the registered occupancy/ready flags.
    always_ff @(posedge pClk or posedge pReset) begin
        if (pReset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifoMem_r[i] <= 8'h00;
            end
            rdPtr_r   <= '0;
            wrPtr_r   <= '0;
            level_r   <= '0;
            wrReady_r <= 1'b1;
        end else begin
            if (pushReq_s) begin
                fifoMem_r[wrPtr_r] <= wr_data;
                wrPtr_r            <= wrPtr_r + PW'(1);
            end
            if (popReq_s) begin
                rdPtr_r <= rdPtr_r + PW'(1);
            end
            level_r   <= levelNext_s;
            wrReady_r <= (levelNext_s != FULL_LEVEL);
        end
    end

    // Line state machine; shift_r[0] always holds the bit currently on tx.
    always_ff @(posedge pClk or posedge pReset) begin
        if (pReset) begin
            state_r  <= IDLE;
            shift_r  <= '1;
            bitCnt_r <= 4'd0;
            tx_r     <= 1'b1;
            busy_r   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (popReq_s) begin
                        shift_r  <= popFrame_s;
                        bitCnt_r <= 4'd0;
                        tx_r     <= 1'b0;
                        busy_r   <= 1'b1;
                        state_r  <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (baud_tick) begin
                        if (bitCnt_r < LAST_BIT) begin
                            shift_r  <= {1'b1, shift_r[10:1]};
                            tx_r     <= shift_r[1];
                            bitCnt_r <= bitCnt_r + 4'd1;
                        end else if (popReq_s) begin
                            shift_r  <= popFrame_s;
                            bitCnt_r <= 4'd0;
                            tx_r     <= 1'b0;
                        end else begin
                            shift_r  <= '1;
                            bitCnt_r <= 4'd0;
                            tx_r     <= 1'b1;
                            busy_r   <= 1'b0;
                            state_r  <= IDLE;
                        end
                    end
                end
                default: begin
                    state_r  <= IDLE;
                    shift_r  <= '1;
                    bitCnt_r <= 4'd0;
                    tx_r     <= 1'b1;
                    busy_r   <= 1'b0;
                end
            endcase
        end
    end

    assign tx         = tx_r;
    assign busy       = busy_r;
    assign fifo_level = level_r;
    assign wr_ready   = wrReady_r;
endmodule

// File: tb/tb_usrt_tx_framer.sv
// Bench for usrt_tx_framer: three parity configurations share one stimulus stream and
// are each checked every cycle against a queue/frame-vector model of the line.
module tb_usrt_tx_framer;
    logic       pClk = 1'b0;
    logic       pReset = 1'b1;
    logic       wr_valid = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       baud_tick = 1'b0;
    logic [2:0] txS;
    logic [2:0] busyS;
    logic [2:0] readyS;
    logic [2:0] levelS [3];

    int nChecks = 0;
    int nFails = 0;

    // Instance 0: even parity, 1: odd parity, 2: no parity.
    usrt_tx_framer #(.FIFO_DEPTH(4), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)) u0 (
        .pClk(pClk), .pReset(pReset), .wr_valid(wr_valid), .wr_data(wr_data),
        .wr_ready(readyS[0]), .baud_tick(baud_tick), .tx(txS[0]), .busy(busyS[0]),
        .fifo_level(levelS[0]));
    usrt_tx_framer #(.FIFO_DEPTH(4), .PARITY_EN(1'b1), .PARITY_ODD(1'b1)) u1 (
        .pClk(pClk), .pReset(pReset), .wr_valid(wr_valid), .wr_data(wr_data),
        .wr_ready(readyS[1]), .baud_tick(baud_tick), .tx(txS[1]), .busy(busyS[1]),
        .fifo_level(levelS[1]));
    usrt_tx_framer #(.FIFO_DEPTH(4), .PARITY_EN(1'b0), .PARITY_ODD(1'b0)) u2 (
        .pClk(pClk), .pReset(pReset), .wr_valid(wr_valid), .wr_data(wr_data),
        .wr_ready(readyS[2]), .baud_tick(baud_tick), .tx(txS[2]), .busy(busyS[2]),
        .fifo_level(levelS[2]));

    always #5 pClk = ~pClk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: a byte FIFO plus the current frame as a bit vector and bit index.
    logic [7:0]  mMem [3][4];
    int          mHead [3];
    int          mCnt [3];
    int          mIdx [3];
    bit          mActive [3];
    logic [10:0] mFrame [3];

    function automatic int nbOf(input int k);
        return (k == 2) ? 10 : 11;
    endfunction

    function automatic logic [10:0] refFrame(input logic [7:0] d, input bit pe, input bit po);
        logic [10:0] f;
        f    = '1;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) f[i+1] = d[i];
        if (pe) f[9] = 1'(($countones(d) + 32'(po)) % 2);
        return f;
    endfunction

    task automatic modelStep(input int k);
        bit ready, canStart, doPop, doPush;
        logic [7:0] head;
        ready    = (mCnt[k] != 4);
        canStart = !mActive[k] || (mIdx[k] == nbOf(k) - 1);
        doPop    = baud_tick && canStart && (mCnt[k] > 0);
        doPush   = wr_valid && ready;
        head     = mMem[k][mHead[k]];
        if (doPop) begin
            mHead[k] = (mHead[k] + 1) % 4;
            mCnt[k]--;
        end
        if (doPush) begin
            mMem[k][(mHead[k] + mCnt[k]) % 4] = wr_data;
            mCnt[k]++;
        end
        if (baud_tick) begin
            if (mActive[k] && mIdx[k] < nbOf(k) - 1) mIdx[k]++;
            else if (doPop) begin
                mFrame[k]  = refFrame(head, k != 2, k == 1);
                mActive[k] = 1'b1;
                mIdx[k]    = 0;
            end else mActive[k] = 1'b0;
        end
    endtask

    always @(posedge pClk) begin
        for (int k = 0; k < 3; k++) begin
            if (pReset) begin
                mHead[k] = 0; mCnt[k] = 0; mIdx[k] = 0; mActive[k] = 1'b0; mFrame[k] = '1;
            end else begin
                modelStep(k);
            end
        end
    end

    always @(negedge pClk) begin
        if (!pReset) begin
            for (int k = 0; k < 3; k++) begin
                check($sformatf("tx[%0d]", k), 32'(txS[k]),
                      32'(mActive[k] ? mFrame[k][mIdx[k]] : 1'b1));
                check($sformatf("busy[%0d]", k), 32'(busyS[k]), 32'(mActive[k]));
                check($sformatf("level[%0d]", k), 32'(levelS[k]), 32'(mCnt[k]));
                check($sformatf("ready[%0d]", k), 32'(readyS[k]), 32'(mCnt[k] != 4));
            end
        end
    end

    logic [2:0]  lastTx;
    logic [2:0]  lastBusy;
    logic [10:0] g0;
    logic [10:0] g1;
    logic [9:0]  g2;
    logic [21:0] g22;
    int          busyCnt;

    task automatic push(input logic [7:0] d);
        wr_valid = 1'b1;
        wr_data  = d;
        @(posedge pClk); #1;
        wr_valid = 1'b0;
    endtask

    task automatic tick();
        baud_tick = 1'b1;
        @(posedge pClk); #1;
        baud_tick = 1'b0;
        lastTx   = txS;
        lastBusy = busyS;
        repeat (15) begin @(posedge pClk); #1; end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((busyS != 3'b000 || levelS[0] != 3'd0 || levelS[1] != 3'd0 ||
                levelS[2] != 3'd0) && n < 100) begin
            tick();
            n++;
        end
        check("drain_idle", 32'(busyS), 32'd0);
    endtask

    initial begin
        repeat (3) @(posedge pClk);
        #1;
        for (int k = 0; k < 3; k++) begin
            check("reset_tx", 32'(txS[k]), 32'd1);
            check("reset_busy", 32'(busyS[k]), 32'd0);
            check("reset_level", 32'(levelS[k]), 32'd0);
            check("reset_ready", 32'(readyS[k]), 32'd1);
        end
        pReset = 1'b0;
        repeat (2) begin @(posedge pClk); #1; end

        // 0xA5, even parity: fixed 11-bit pattern, then idle.
        push(8'hA5);
        busyCnt = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (i < 11) g0[i] = lastTx[0];
            busyCnt += int'(lastBusy[0]);
        end
        check("a5_bits", 32'(g0), 32'(11'b10101001010));
        check("a5_busy_ticks", 32'(busyCnt), 32'd11);
        check("a5_end_tx", 32'(txS[0]), 32'd1);
        check("a5_end_busy", 32'(busyS[0]), 32'd0);

        // 0x00 then 0xFF back-to-back.
        push(8'h00);
        push(8'hFF);
        check("b2b_level2", 32'(levelS[0]), 32'd2);
        busyCnt = 0;
        for (int i = 0; i < 23; i++) begin
            tick();
            if (i < 22) g22[i] = lastTx[0];
            busyCnt += int'(lastBusy[0]);
            if (i == 0)  check("b2b_level1", 32'(levelS[0]), 32'd1);
            if (i == 11) check("b2b_level0", 32'(levelS[0]), 32'd0);
        end
        check("b2b_bits", 32'(g22), 32'(22'b1011111111010000000000));
        check("b2b_busy_ticks", 32'(busyCnt), 32'd22);
        drain();

        // Overfill: fifth byte dropped.
        for (int i = 0; i < 5; i++) begin
            push(8'(8'h10 + i));
            check($sformatf("full_ready_%0d", i), 32'(readyS[0]), (i < 3) ? 32'd1 : 32'd0);
        end
        check("full_level", 32'(levelS[0]), 32'd4);
        tick();
        check("full_level_after_pop", 32'(levelS[0]), 32'd3);
        check("full_ready_after_pop", 32'(readyS[0]), 32'd1);
        drain();

        // 0x01 with odd parity and without parity.
        push(8'h01);
        for (int i = 0; i < 12; i++) begin
            tick();
            if (i < 11) g1[i] = lastTx[1];
            if (i < 10) g2[i] = lastTx[2];
        end
        check("odd_parity_bit", 32'(g1[9]), 32'd0);
        check("nopar_bits", 32'(g2), 32'(10'b1000000010));
        drain();

        // Asynchronous reset at data bit 3 with bytes still queued.
        push(8'h77);
        push(8'h11);
        push(8'h22);
        repeat (5) tick();
        check("pre_reset_busy", 32'(busyS[0]), 32'd1);
        @(posedge pClk); #3;
        pReset = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) begin
            check("async_tx", 32'(txS[k]), 32'd1);
            check("async_busy", 32'(busyS[k]), 32'd0);
            check("async_level", 32'(levelS[k]), 32'd0);
        end
        @(posedge pClk); #1;
        pReset = 1'b0;
        @(posedge pClk); #1;
        push(8'h3C);
        for (int i = 0; i < 12; i++) begin
            tick();
            if (i < 11) g0[i] = lastTx[0];
        end
        check("post_reset_3c", 32'(g0), 32'(11'b10001111000));
        drain();

        // Push and pop on the same edge at level 2.
        push(8'h5A);
        push(8'hC3);
        wr_valid  = 1'b1;
        wr_data   = 8'h99;
        baud_tick = 1'b1;
        @(posedge pClk); #1;
        wr_valid  = 1'b0;
        baud_tick = 1'b0;
        check("pushpop_level", 32'(levelS[0]), 32'd2);
        drain();

        // Randomized traffic: dense ticks first, then sparse.
        for (int c = 0; c < 4000; c++) begin
            wr_valid  = ($urandom_range(0, 3) == 0);
            wr_data   = 8'($urandom);
            baud_tick = (c < 2000) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 9) == 0);
            @(posedge pClk); #1;
        end
        wr_valid  = 1'b0;
        baud_tick = 1'b0;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end
endmodule
